// File: rtl/produto_escalar_stream.sv
// Streaming dot product: accepts i_len operand pairs, multiplies in stage 1,
// accumulates in stage 2, and holds the full-precision result in DONE.
module produto_escalar_stream #(
  parameter  int DATA_W  = 32,
  parameter  int MAX_LEN = 64,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1,
  localparam int ACC_W   = 2 * DATA_W + LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_signed,
  input  logic              i_abort,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ACC_W-1:0]  o_result
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic                       sgn_q;
  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           cnt;
  logic [LEN_W-1:0]           cnt_inc;
  logic                       len_ok;
  logic                       start_ok;
  logic                       abort_ok;
  logic                       xfer;
  logic signed [2*DATA_W-1:0] prod_p0;
  logic signed [2*DATA_W-1:0] prod_p1;
  logic                       vld_p1;
  logic signed [ACC_W-1:0]    acc_p2;
  logic signed [ACC_W-1:0]    acc_sum;

  // One extra bit lets a single signed multiplier serve both operand modes.
  function automatic logic signed [DATA_W:0] ext_operand(input logic [DATA_W-1:0] v,
                                                         input logic sgn);
    return sgn ? {v[DATA_W-1], v} : {1'b0, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_product(input logic signed [2*DATA_W-1:0] p,
                                                          input logic sgn);
    return sgn ? {{LEN_W{p[2*DATA_W-1]}}, p} : {{LEN_W{1'b0}}, p};
  endfunction

  assign o_ready  = (state == RUN);
  assign o_busy   = (state == RUN) || (state == DRAIN);
  assign len_ok   = (i_len != '0) && (i_len <= LEN_W'(MAX_LEN));
  assign start_ok = i_start && ((state == IDLE) || (state == DONE));
  assign abort_ok = i_abort && o_busy;
  assign xfer     = i_valid && o_ready && !i_abort;
  assign cnt_inc  = cnt + 1'b1;

  always_comb begin
    prod_p0 = ext_operand(i_a, sgn_q) * ext_operand(i_b, sgn_q);
    acc_sum = acc_p2 + ext_product(prod_p1, sgn_q);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (i_start) state_nx = len_ok ? RUN : DONE;
      RUN: begin
        if (i_abort)                       state_nx = IDLE;
        else if (xfer && cnt_inc == len_q) state_nx = DRAIN;
      end
      DRAIN:   state_nx = i_abort ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sgn_q    <= 1'b0;
      len_q    <= '0;
      cnt      <= '0;
      prod_p1  <= '0;
      vld_p1   <= 1'b0;
      acc_p2   <= '0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_result <= '0;
    end else begin
      state <= state_nx;
      // stage 0 -> 1: register the full-precision product
      vld_p1 <= xfer;
      if (xfer) prod_p1 <= prod_p0;
      if (start_ok) begin
        sgn_q  <= i_signed;
        len_q  <= i_len;
        cnt    <= '0;
        acc_p2 <= '0;
        o_err  <= !len_ok;
        o_done <= !len_ok;
        if (!len_ok) o_result <= '0;
      end else if (abort_ok) begin
        vld_p1 <= 1'b0;
        o_done <= 1'b0;
        o_err  <= 1'b0;
      end else begin
        if (xfer) cnt <= cnt_inc;
        // stage 1 -> 2: accumulate; the last product completes in DRAIN
        if (vld_p1) acc_p2 <= acc_sum;
        if (state == DRAIN) begin
          o_result <= acc_sum;
          o_done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_produto_escalar_stream.sv
// Directed bench for produto_escalar_stream with hand-computed expectations.
module tb_produto_escalar_stream;
  localparam int DATA_W  = 32;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int ACC_W   = 2 * DATA_W + LEN_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic [LEN_W-1:0]  i_len = '0;
  logic              i_signed = 1'b0;
  logic              i_abort = 1'b0;
  logic              i_valid = 1'b0;
  logic [DATA_W-1:0] i_a = '0;
  logic [DATA_W-1:0] i_b = '0;
  logic              o_ready, o_busy, o_done, o_err;
  logic [ACC_W-1:0]  o_result;

  int n_tests = 0;
  int n_fail  = 0;

  produto_escalar_stream #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len), .i_signed(i_signed),
    .i_abort(i_abort), .i_valid(i_valid), .i_a(i_a), .i_b(i_b),
    .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_result(o_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ACC_W-1:0] acc_of(input longint v);
    return ACC_W'(v);
  endfunction

  task automatic start(input int len, input logic sgn);
    i_start  = 1'b1;
    i_len    = LEN_W'(len);
    i_signed = sgn;
    tick();
    i_start  = 1'b0;
  endtask

  int rdy_cnt;
  int not_busy;
  int ai;
  logic [6:0] pat;

  initial begin
    // reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready",  o_ready,  0);
    chk("rst_busy",   o_busy,   0);
    chk("rst_done",   o_done,   0);
    chk("rst_err",    o_err,    0);
    chk("rst_result", o_result, 0);

    // signed len 8: a=1..8, b=-1..-8 -> -204
    start(8, 1'b1);
    chk("s8_busy", o_busy, 1);
    chk("s8_done", o_done, 0);
    rdy_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1;
      i_a = DATA_W'(k);
      i_b = DATA_W'(-k);
      if (o_ready) rdy_cnt++;
      tick();
    end
    i_valid = 1'b0;
    chk("s8_ready_cycles", rdy_cnt, 8);
    chk("s8_drain_ready", o_ready, 0);
    chk("s8_drain_done",  o_done,  0);
    chk("s8_drain_busy",  o_busy,  1);
    tick();
    chk("s8_done",   o_done,   1);
    chk("s8_result", o_result, acc_of(-204));
    chk("s8_idle_busy", o_busy, 0);
    tick();
    chk("s8_hold_done",   o_done,   1);
    chk("s8_hold_result", o_result, acc_of(-204));

    // unsigned len 2, max operands
    start(2, 1'b0);
    chk("u2_done_clr",    o_done,   0);
    chk("u2_result_hold", o_result, acc_of(-204));
    i_valid = 1'b1; i_a = '1; i_b = '1;
    tick(); tick();
    i_valid = 1'b0;
    tick();
    chk("u2_done",   o_done,   1);
    chk("u2_result", o_result, 128'h1_FFFFFFFC_00000002);

    // signed len 4 with gaps and an ignored mid-run start -> 14
    start(4, 1'b1);
    pat = 7'b1011001;  // bit 0 first: 1,0,0,1,1,0,1
    ai = 2;
    not_busy = 0;
    for (int c = 0; c < 7; c++) begin
      i_valid = pat[c];
      i_a = DATA_W'(ai);
      i_b = 1;
      i_start = (c == 2);
      i_len = 1;
      if (!o_busy) not_busy++;
      if (c == 3) chk("g4_result_hold", o_result, 128'h1_FFFFFFFC_00000002);
      tick();
      if (pat[c]) ai++;
    end
    i_valid = 1'b0; i_start = 1'b0;
    chk("g4_drain_busy", o_busy, 1);
    chk("g4_drain_done", o_done, 0);
    tick();
    chk("g4_busy_gap", not_busy, 0);
    chk("g4_done",   o_done,   1);
    chk("g4_result", o_result, acc_of(14));

    // illegal lengths
    start(0, 1'b1);
    chk("len0_err",    o_err,    1);
    chk("len0_done",   o_done,   1);
    chk("len0_result", o_result, 0);
    chk("len0_ready",  o_ready,  0);
    start(MAX_LEN + 1, 1'b1);
    chk("len65_err",    o_err,    1);
    chk("len65_done",   o_done,   1);
    chk("len65_result", o_result, 0);
    chk("len65_ready",  o_ready,  0);
    start(MAX_LEN, 1'b1);
    chk("lenmax_err", o_err, 0);
    chk("lenmax_ready", o_ready, 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;

    // abort after 3 transfers; the pair in the abort cycle is discarded
    start(8, 1'b1);
    chk("ab_err_clr", o_err, 0);
    i_valid = 1'b1; i_a = 1; i_b = 1;
    tick(); tick(); tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0; i_valid = 1'b0;
    chk("ab_busy",   o_busy,   0);
    chk("ab_ready",  o_ready,  0);
    chk("ab_done",   o_done,   0);
    chk("ab_result", o_result, 0);
    tick(); tick(); tick();
    chk("ab_done_late", o_done, 0);
    start(1, 1'b1);
    i_valid = 1'b1; i_a = DATA_W'(-3); i_b = 7;
    tick();
    i_valid = 1'b0;
    tick();
    chk("ab_new_done",   o_done,   1);
    chk("ab_new_result", o_result, acc_of(-21));

    // abort in DONE ignored; start+abort in DONE starts
    i_abort = 1'b1;
    tick();
    chk("done_abort_ign", o_done, 1);
    i_start = 1'b1; i_len = 1; i_signed = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    chk("start_wins_busy", o_busy, 1);
    chk("start_wins_done", o_done, 0);

    // reset during DRAIN
    i_valid = 1'b1; i_a = 5; i_b = 5;
    tick();
    i_valid = 1'b0;
    chk("rd_in_drain", o_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rd_busy",   o_busy,   0);
    chk("rd_ready",  o_ready,  0);
    chk("rd_done",   o_done,   0);
    chk("rd_result", o_result, 0);
    tick(); tick();
    chk("rd_no_done", o_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/produto_escalar_stream.md
PRODUTO_ESCALAR_STREAM -- requirements
Module: produto_escalar_stream

Interface
REQ-001 Parameter DATA_W, default 32, operand width in bits.
REQ-002 Parameter MAX_LEN, default 64, maximum vector length (>=2).
REQ-003 Derived LEN_W = clog2(MAX_LEN)+1; ACC_W = 2*DATA_W + LEN_W.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 i_start  input  1  request a new dot product; sampled only in IDLE or DONE.
REQ-007 i_len  input  LEN_W  vector length, latched with start.
REQ-008 i_signed  input  1  1 = two's-complement operands, 0 = unsigned; latched with start.
REQ-009 i_abort  input  1  cancel the running computation.
REQ-010 i_valid  input  1  operand pair i_a/i_b valid.
REQ-011 i_a, i_b  input  DATA_W each  current element pair.
REQ-012 o_ready  output  1  block accepts a pair this cycle.
REQ-013 o_busy  output  1  high in RUN and DRAIN.
REQ-014 o_done  output  1  result valid, held.
REQ-015 o_err  output  1  last start had an illegal length, held.
REQ-016 o_result  output  ACC_W  dot product; two's-complement if signed mode, else unsigned.

Function
REQ-017 States: IDLE, RUN, DRAIN, DONE. DONE accepts a new start exactly like IDLE.
REQ-018 Start accepted when i_start=1 in IDLE/DONE. Next cycle: o_done=0, o_err=0, accumulator=0, element count=0, i_len/i_signed latched.
REQ-019 Start with i_len=0 or i_len>MAX_LEN: go to DONE next cycle, o_err=1, o_done=1, o_result=0; no pairs accepted.
REQ-020 Legal start: go to RUN. o_ready = 1 in RUN only. Pair transfers when i_valid && o_ready; count increments per transfer.
REQ-021 i_valid low in RUN stalls without limit; no timeout.
REQ-022 On transfer of pair number i_len, o_ready drops next cycle and state goes to DRAIN.
REQ-023 Two-stage pipeline: stage 1 registers full-precision product (2*DATA_W, sign- or zero-extended per mode); stage 2 adds it to the ACC_W accumulator, extended per mode.
REQ-024 Latency: o_done=1 and o_result final in cycle L+2, where L is the cycle of the last transfer; state = DONE then.
REQ-025 ACC_W is sized so no overflow occurs for any legal length; no saturation logic.
REQ-026 o_done and o_result hold in DONE until next accepted start or reset; o_result is not updated during RUN/DRAIN (holds previous value until completion).
REQ-027 i_start in RUN/DRAIN is ignored; no effect on the current computation.
REQ-028 i_abort in RUN/DRAIN: return to IDLE next cycle, pipeline flushed, o_done=0, o_err=0, o_result unchanged; any pair presented that same cycle is discarded.
REQ-029 i_abort has priority over a transfer in the same cycle; i_abort in IDLE/DONE is ignored.
REQ-030 i_start and i_abort both high in DONE: start wins.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, o_ready=0, o_busy=0, o_done=0, o_err=0, o_result=0, accumulator/count/pipeline cleared.
REQ-032 Reset mid-RUN or mid-DRAIN discards the computation; no o_done pulse follows.

Verification
REQ-033 Signed, len=8, a={1..8}, b={-1..-8}, i_valid always high -> o_ready high 8 cycles; o_done 2 cycles after last transfer, o_result = -204.
REQ-034 Unsigned, len=2, a=b=32'hFFFFFFFF -> o_result = 2*(2^32-1)^2 = 0x1_FFFFFFFC_00000002, no overflow.
REQ-035 Signed, len=4, i_valid toggled 1,0,0,1,1,0,1 with a={2,3,4,5}, b=1 -> o_result=14; o_busy high until DONE; i_start pulsed mid-RUN ignored.
REQ-036 len=0, then len=MAX_LEN+1 -> each: o_err=1, o_done=1, o_result=0 next cycle; o_ready never high.
REQ-037 len=8, i_abort after 3 transfers -> IDLE next cycle, o_done stays 0; new start len=1, a=-3, b=7 signed -> o_result=-21.
REQ-038 rst asserted during DRAIN -> all outputs 0 next cycle, no o_done afterwards.
